bcd_display_scheduler: RTL

Sequential controller that accepts a 20-bit binary value, converts it to six BCD digits with a shift-add-3 (double-dabble) engine running one bit per clock, and time-multiplexes the result onto a single shared 7-segment bus with six digit enables. It sits between the counting/measurement logic and the board's six-digit display. It replaces six parallel decoders with one shared decoder plus a refresh scheduler. The previously committed digits stay on the display during a conversion, so the display never shows partial results.

---
 rtl/bcd_display_scheduler.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/bcd_display_scheduler.sv
// Binary-to-BCD converter (shift-add-3, one bit per clock) driving a six-digit
// multiplexed 7-segment display through one shared decoder and a refresh scan.
module bcd_display_scheduler #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] value_in,
  input  logic        value_valid,
  output logic        ready,
  input  logic        blank_lz,
  output logic        ovf,
  output logic [6:0]  seg_out,
  output logic [5:0]  dig_en
);

  localparam int unsigned   PW           = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST   = PW'(REFRESH_DIV - 1);
  localparam logic [19:0]   MAX_IN_RANGE = 20'd999999;
  localparam logic [4:0]    LAST_BIT     = 5'd19;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_COMMIT
  } state_t;

  state_t        r_state;
  logic [19:0]   r_src;
  logic [23:0]   r_work;
  logic [4:0]    r_bit_cnt;
  logic          r_ovf_pending;
  logic          r_ready;
  logic          r_ovf;
  logic [23:0]   r_disp;
  logic [PW-1:0] r_presc;
  logic [2:0]    r_idx;
  logic [6:0]    r_seg;
  logic [5:0]    r_dig;

  logic [23:0]   w_work_adj;
  logic [3:0]    w_nib [6];
  logic [5:0]    w_upper_zero;
  logic [5:0]    w_blank;
  logic [6:0]    w_seg_next;

  genvar gi;

  // Add-3 correction applied to every work nibble before each shift.
  generate
    for (gi = 0; gi < 6; gi++) begin : g_adj
      assign w_work_adj[4*gi +: 4] = (r_work[4*gi +: 4] >= 4'd5) ?
                                     (r_work[4*gi +: 4] + 4'd3) : r_work[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_src         <= '0;
      r_work        <= '0;
      r_bit_cnt     <= '0;
      r_ovf_pending <= 1'b0;
      r_ready       <= 1'b1;
      r_ovf         <= 1'b0;
      r_disp        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (value_valid) begin
            r_src         <= value_in;
            r_work        <= '0;
            r_bit_cnt     <= '0;
            r_ovf_pending <= (value_in > MAX_IN_RANGE);
            r_ready       <= 1'b0;
            r_state       <= S_CONV;
          end
        end
        S_CONV: begin
          r_work    <= {w_work_adj[22:0], r_src[19]};
          r_src     <= {r_src[18:0], 1'b0};
          r_bit_cnt <= r_bit_cnt + 5'd1;
          if (r_bit_cnt == LAST_BIT) begin
            r_state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          // Out-of-range values show 'E' on every digit rather than a truncated number.
          r_disp  <= r_ovf_pending ? 24'hEEEEEE : r_work;
          r_ovf   <= r_ovf_pending;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Digit k is a leading zero when it and every more significant digit are zero.
  assign w_upper_zero[5] = (r_disp[23:20] == 4'd0);
  generate
    for (gi = 0; gi < 5; gi++) begin : g_upper
      assign w_upper_zero[gi] = (r_disp[4*gi +: 4] == 4'd0) & w_upper_zero[gi+1];
    end
    for (gi = 0; gi < 6; gi++) begin : g_blank
      assign w_nib[gi] = r_disp[4*gi +: 4];
      if (gi == 0) begin : g_units
        assign w_blank[gi] = 1'b0;
      end else begin : g_upper_dig
        assign w_blank[gi] = blank_lz & ~r_ovf & w_upper_zero[gi];
      end
    end
  endgenerate

  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  assign w_seg_next = w_blank[r_idx] ? 7'h7F : seg_decode(w_nib[r_idx]);

  // Scan runs independently of conversions; outputs are registered from the
  // same index so segments and enables always change on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_seg   <= 7'b1000000;
      r_dig   <= 6'b111110;
    end else begin
      if (r_presc == PRESC_LAST) begin
        r_presc <= '0;
        r_idx   <= (r_idx == 3'd5) ? 3'd0 : (r_idx + 3'd1);
      end else begin
        r_presc <= r_presc + PW'(1);
      end
      r_seg <= w_seg_next;
      r_dig <= ~(6'b000001 << r_idx);
    end
  end

  assign ready   = r_ready;
  assign ovf     = r_ovf;
  assign seg_out = r_seg;
  assign dig_en  = r_dig;

endmodule
